// File: rtl/gate_sweep_checker_pkg.sv
// Shared encodings for the exhaustive gate sweep checker.
package gate_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_NAND = 3'd1,
    GATE_OR   = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return mode <= 3'd5;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Control/status and gate-under-test bus of the sweep checker.
interface gate_sweep_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic [2:0]       mode;
  logic [N_IN-1:0]  stim;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_vld;
  logic [N_IN-1:0]  fail_vec;

  // master: host plus gate under test; slave: the checker itself
  modport master (output start, mode, dut_y,
                  input  stim, busy, done, pass, err_cnt, fail_vld, fail_vec);
  modport slave  (input  start, mode, dut_y,
                  output stim, busy, done, pass, err_cnt, fail_vld, fail_vec);
endinterface

// File: rtl/gate_sweep_checker_ref_model.sv
// Combinational reference gate: (mode, vector) -> expected output.
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] vec,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (mode)
      GATE_AND:  y = &vec;
      GATE_NAND: y = ~&vec;
      GATE_OR:   y = |vec;
      GATE_NOR:  y = ~|vec;
      GATE_XOR:  y = ^vec;
      GATE_XNOR: y = ~^vec;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweep of a gate under test against gate_ref_model.
// GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 1,
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_sweep_if.slave  bus
);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif
  localparam logic [7:0] DWELL_LD = 8'(DWELL);

  sweep_state_e     state;
  logic [2:0]       mode_q;
  logic [7:0]       dwell_cnt;
  logic [N_IN-1:0]  stim_q, fail_vec_q;
  logic [ERR_W-1:0] err_q, err_inc;
  logic             busy_q, done_q, pass_q, fail_vld_q;
  logic             ref_y, mism, last_vec, stop;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .mode (mode_q),
    .vec  (stim_q),
    .y    (ref_y)
  );

  assign mism     = bus.dut_y != ref_y;
  assign last_vec = &stim_q;
  assign stop     = last_vec || (STOP_ON_FAIL && mism);
  assign err_inc  = (&err_q) ? err_q : err_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= 3'd0;
      dwell_cnt  <= 8'd0;
      stim_q     <= '0;
      fail_vec_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vld_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          err_q      <= '0;
          pass_q     <= 1'b0;
          fail_vld_q <= 1'b0;
          fail_vec_q <= '0;
          if (mode_legal(bus.mode)) begin
            mode_q    <= bus.mode;
            stim_q    <= '0;
            dwell_cnt <= DWELL_LD;
            busy_q    <= 1'b1;
            state     <= ST_RUN;
          end else begin
            // reserved mode: report an immediate failed sweep, stim untouched
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else begin
            if (mism) begin
              err_q <= err_inc;
              if (!fail_vld_q) begin
                fail_vld_q <= 1'b1;
                fail_vec_q <= stim_q;
              end
            end
            if (stop) begin
              // results become final together with the done pulse
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_q == '0) && !mism;
              state  <= ST_DONE;
            end else begin
              stim_q    <= stim_q + 1'b1;
              dwell_cnt <= DWELL_LD;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stim     = stim_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vld = fail_vld_q;
  assign bus.fail_vec = fail_vec_q;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Parametrised, synthesisable exhaustive-sweep checker for N-input basic logic gates. On `start` it drives every input vector 0 … 2^N_IN−1 onto a gate under test, holds each one for a programmable settle time, and compares the gate output against a built-in reference for the selected gate type. It reports pass/fail, a saturating error count and the first failing vector. It sits beside any combinational gate block as on-chip self-test, replacing hand-written stimulus sequences.

## Interface
- `N_IN`, 2, gate input count (1..8); sweep length is 2^N_IN vectors.
- `DWELL`, 1, settle cycles per vector before sampling (0..255).
- `ERR_W`, 8, width of error counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `mode`  in  3  gate type, captured at start: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6–7 reserved.
- `stim`  out  N_IN  vector driven to the gate under test.
- `dut_y`  in  1  gate-under-test output.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  last sweep had zero mismatches and a legal mode.
- `err_cnt`  out  ERR_W  mismatch count, saturating at 2^ERR_W−1.
- `fail_vld`  out  1  `fail_vec` is valid.
- `fail_vec`  out  N_IN  first mismatching vector of the last sweep.

## Operation
- Reset: every output is 0 and the state is IDLE.
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `start`=1 with a legal mode: capture mode; clear `err_cnt`, `pass`, `fail_vld`, `fail_vec`; set `stim`=0; load the dwell counter with DWELL; go to RUN.
  - `start`=1 with a reserved mode: go straight to DONE with `pass`=0, `err_cnt`=0 and no sweep.
- RUN:
  - Each vector is held for DWELL+1 cycles.
  - On the last cycle of each vector, compare `dut_y` with the reference value for (captured mode, `stim`).
  - On mismatch, increment `err_cnt` with saturation. On the first mismatch only, set `fail_vld`=1 and `fail_vec`=`stim`.
  - After sampling, increment `stim` and reload the dwell counter. Sampling the all-ones vector ends the sweep: go to DONE.
- DONE: assert `done` for one cycle; `pass` = (`err_cnt`==0); return to IDLE.
- Results hold until the next accepted `start`.
- `start` and `mode` are ignored while `busy`.
- `start` held high re-launches a sweep on the cycle after DONE.
- `stim` holds its last vector in IDLE.
- Reset asserted mid-sweep aborts the sweep immediately; no `done` is issued.

## Timing
- Take the cycle in which `start` is sampled as cycle 0.
- `busy` is high from cycle 1 through cycle 2^N_IN·(DWELL+1).
- `done` is high in cycle 2^N_IN·(DWELL+1)+1.
- `stim` changes at cycle 1 and then every DWELL+1 cycles.
- `dut_y` is sampled DWELL cycles after each `stim` change, so the gate under test has DWELL cycles to settle (combinational gate: DWELL=0 is legal).
- Reserved mode: `done` in cycle 1; `busy` never asserts.
- `pass`, `err_cnt` and `fail_*` are registered and final in the `done` cycle.

## Configuration
- `GATE_SWEEP_STOP_ON_FAIL_EN` defined: the first mismatch ends the sweep. The FSM goes to DONE in the cycle after that sample, with `err_cnt`=1 and `fail_vec` set.
- Not defined: the full sweep always runs and all mismatches are counted.

## Structure
- Package `gate_pkg` holds:
  - mode encodings (`GATE_AND` … `GATE_XNOR`);
  - state encodings;
  - the `mode_legal` check.
- Sub-module `gate_ref_model`: combinational reference, (mode, vector) → expected y. It uses the N_IN-wide reduction for each gate type and is reusable by other benches.

## Test plan
- N_IN=2, DWELL=1, mode=1 (NAND), `dut_y`=~&`stim`:
  - `stim` reads 00,00,01,01,10,10,11,11 over cycles 1–8;
  - `done` in cycle 9, `pass`=1, `err_cnt`=0, `fail_vld`=0.
- Same setup, `dut_y` stuck at 1 → `err_cnt`=1, `fail_vec`=2'b11, `pass`=0.
- mode=4 (XOR), `dut_y`=0:
  - macro undefined: `err_cnt`=2, `fail_vec`=2'b01, `done` in cycle 9;
  - macro defined: `err_cnt`=1, `done` in cycle 5.
- mode=6 → `done` in cycle 1, `pass`=0, `busy` never high, `stim` unchanged.
- `rst_n` low while `stim`=2'b10 → all outputs 0 at once, no `done`; the next `start` sweeps again from 00.
- N_IN=3, DWELL=0, mode=3 (NOR):
  - `start` re-pulsed and `mode` changed to 0 mid-sweep are both ignored;
  - 8 vectors are checked as NOR, `done` in cycle 9, `pass`=1;
  - `err_cnt` saturation is checked with ERR_W=1 and an inverted `dut_y` → `err_cnt`=1.
